// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit XOR datapath among NUM_REQ requesters.
// One operation in flight; the tagged result is held until the consumer accepts it.
//
// state | meaning
// IDLE  | arbitrate, handshake with the winner, latch its operands
// EXEC  | shared XOR evaluates the latched operands
// RESP  | result valid, held until resp_ready
module xor_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic [ID_W-1:0]         resp_id,
  input  logic                    resp_ready,
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [15:0]     op_count_q, op_count_d;

  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic [31:0]     sel_a, sel_b;
  logic [31:0]     xor_out;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
        req_ready[i] = grant_any && (state_q == IDLE);
      end
    end
  end

  assign xor_out = op_a_q ^ op_b_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_a_d    = sel_a;
          op_b_d    = sel_b;
          resp_id_d = grant_idx;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = xor_out;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign op_count   = op_count_q;

endmodule

// File: doc/xor_unit_arbiter.md
Name: xor_unit_arbiter

Overview:
- Shares one 32-bit bitwise XOR datapath among NUM_REQ requesters in the sequential processor, for example the ALU XOR path, the checksum engine and the debug port.
- Grants requesters round-robin, latches the granted operands, sequences the shared XOR unit, and holds the tagged result until the consumer accepts it.
- Exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, 2: width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, NUM_REQ: bit i set means requester i has an operation pending.
- req_a, input, NUM_REQ*32: operand A; requester i uses bits [32*i+31:32*i].
- req_b, input, NUM_REQ*32: operand B; same slicing as req_a.
- req_ready, output, NUM_REQ: one-hot accept strobe. Bit i set together with req_valid[i] means the operation transfers on that edge.
- resp_valid, output, 1: resp_data and resp_id are valid.
- resp_data, output, 32: req_a XOR req_b of the granted request.
- resp_id, output, ID_W: index of the requester that owns resp_data.
- resp_ready, input, 1: consumer accepts the response.
- busy, output, 1: high whenever state is not IDLE.
- op_count, output, 16: count of completed responses; wraps.

Behaviour:
- Reset (synchronous, checked at the clock edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, op_count=0.
  - Operand registers are cleared to 0.
- Reset takes priority over every other event, including mid-operation. Any in-flight operation and undelivered result are discarded. op_count is not incremented.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and asserted only in IDLE.
  - Winner g is the first set bit of req_valid searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 if any req_valid bit is set; otherwise req_ready is all 0 and the FSM stays in IDLE.
  - On the edge where the handshake occurs: latch req_a and req_b slice g into the operand registers, latch g into resp_id, set rr_ptr=(g+1) mod NUM_REQ, go to EXEC.
- EXEC (exactly 1 cycle):
  - The shared XOR unit is driven from the operand registers.
  - On the edge: resp_data <= opA ^ opB, go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are held stable while resp_ready=0, with unbounded backpressure.
  - On the edge with resp_ready=1: resp_valid drops, op_count increments (16'hFFFF+1 wraps to 0), go to IDLE.
  - resp_data and resp_id keep their last values after delivery.
- Latency and throughput:
  - Handshake at edge T means resp_valid is high in the cycle after edge T+1, i.e. visible from T+2 onward.
  - Best-case throughput is one operation per 3 cycles, with resp_ready tied high.
  - There is no RESP->EXEC bypass; IDLE is always revisited.
- Requester protocol:
  - req_valid may deassert without a handshake; no operation is lost or started.
  - Operands are sampled only on the handshake edge.
  - req_ready is never asserted outside IDLE, so requests raised during EXEC or RESP wait.
- rr_ptr changes only on a grant. An idle cycle does not advance it.
- Fairness: with all requesters continuously valid, the grant order after reset is 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 grants.
- Simultaneous events:
  - A new req_valid arriving in the same cycle as the RESP->IDLE edge is arbitrated in the following IDLE cycle.
  - If reset and resp_ready are high on the same edge, reset wins.

Test Plan:
1. Reset, then req_valid=4'b0001 with req_a[0]=32'hFFFF0000, req_b[0]=32'h0F0F0F0F, resp_ready=1 -> req_ready=4'b0001 for 1 cycle; 2 cycles later resp_valid=1, resp_data=32'hF0F00F0F, resp_id=0; op_count=1.
2. req_valid=4'b1111 held, each requester using a distinct operand pair, resp_ready=1 -> resp_id sequence 0,1,2,3,0; each result equals its own a^b; successive req_ready pulses are 3 cycles apart.
3. req_valid=4'b1010 with rr_ptr=0 -> grant order 1,3,1; rr_ptr after the first grant equals 2.
4. Response held with resp_ready=0 for 10 cycles and req_valid[2]=1 meanwhile -> resp_valid and resp_data stable for all 10 cycles; req_ready=0 throughout; requester 2 is granted the first IDLE cycle after resp_ready=1.
5. Reset asserted during EXEC with operands 32'hAAAAAAAA and 32'h55555555 -> next cycle: state IDLE, resp_valid=0, resp_data=0, op_count unchanged at its reset value 0, rr_ptr=0.
6. op_count preloaded by running 65536 operations -> op_count wraps to 16'h0000 on the 65536th delivery with no glitch on resp_valid.
